// File: rtl/gmii_rx_parser.sv
// GMII receive parser: strips preamble/SFD, validates Eth/IPv4/UDP headers and FCS,
// and splits the UDP payload into video pixel-pair writes and aux byte writes.
module gmii_rx_parser #(
  parameter logic [47:0] MY_MAC    = 48'h002345678902,
  parameter logic [15:0] UDP_DPORT = 16'h3039,
  parameter logic [10:0] PIX_BYTES = 11'd1280
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        pix_we,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [11:0] line_num,
  output logic        aux_we,
  output logic [7:0]  aux_data,
  output logic        frame_end,
  output logic        frame_ok,
  output logic [15:0] err_cnt
);

  typedef enum logic [3:0] {IDLE, PRE, HDR, PID, LINE, VIDEO, AUX, DONE, DROP} state_t;

  localparam int unsigned HDR_LAST    = 41;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
  // Residue in MSB-first form; the register runs LSB-first, so it is compared bit-reversed.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  state_t          state_q;
  logic [3:0][7:0] dly_q;
  logic [3:0]      vld_q;
  logic [31:0]     crc_q, crc_d, crc_rev_c;
  logic            crc_en_q;
  logic            arm_q, sfd_seen_q, surplus_q;
  logic [5:0]      idx_q;
  logic [7:0]      line_lo_q, y_q;
  logic [10:0]     vcnt_q;
  logic            pix_we_q, aux_we_q, frame_end_q, frame_ok_q;
  logic [15:0]     pix_data_q, err_cnt_q;
  logic [9:0]      pix_x_q;
  logic [11:0]     line_num_q;
  logic [7:0]      aux_data_q;
  logic [7:0]      pb_c;
  logic            pvld_c, crc_good_c, in_frame_c, ok_c;

  // One byte of reflected CRC-32.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  // Header byte check at a given index; unchecked positions always pass.
  function automatic logic hdr_byte_ok(input logic [5:0] idx, input logic [7:0] b);
    case (idx)
      6'd0:    return b == MY_MAC[47:40];
      6'd1:    return b == MY_MAC[39:32];
      6'd2:    return b == MY_MAC[31:24];
      6'd3:    return b == MY_MAC[23:16];
      6'd4:    return b == MY_MAC[15:8];
      6'd5:    return b == MY_MAC[7:0];
      6'd12:   return b == 8'h08;
      6'd13:   return b == 8'h00;
      6'd23:   return b == 8'h11;
      6'd36:   return b == UDP_DPORT[15:8];
      6'd37:   return b == UDP_DPORT[7:0];
      default: return 1'b1;
    endcase
  endfunction

  // Parser input: byte leaving stage 4, valid only while the frame is still live.
  always_comb begin
    pb_c   = dly_q[3];
    pvld_c = vld_q[3] & rx_dv;
    crc_d  = crc_step(crc_q, rxd);
    crc_rev_c = '0;
    for (int i = 0; i < 32; i++) crc_rev_c[i] = crc_q[31-i];
    crc_good_c = (crc_rev_c == CRC_RESIDUE);
    in_frame_c = (state_q inside {HDR, PID, LINE, VIDEO, AUX, DONE}) ||
                 ((state_q == DROP) && sfd_seen_q);
    ok_c = crc_good_c && ((state_q == AUX) || ((state_q == DONE) && !surplus_q));
  end

  // 4-stage byte delay with per-stage valid; a gap in rx_dv flushes the valids.
  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      dly_q <= '0;
      vld_q <= '0;
    end else begin
      dly_q <= {dly_q[2:0], rxd};
      vld_q <= rx_dv ? {vld_q[2:0], 1'b1} : 4'b0000;
    end
  end

  // CRC over live rxd from the byte after SFD through FCS.
  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      crc_q    <= 32'hFFFFFFFF;
      crc_en_q <= 1'b0;
    end else if (!rx_dv) begin
      crc_en_q <= 1'b0;
    end else if (!crc_en_q) begin
      if (arm_q && (rxd == 8'hD5)) begin
        crc_en_q <= 1'b1;
        crc_q    <= 32'hFFFFFFFF;
      end
    end else begin
      crc_q <= crc_d;
    end
  end

  // Frame parser FSM with registered write strobes and frame status.
  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      arm_q       <= 1'b0;
      sfd_seen_q  <= 1'b0;
      surplus_q   <= 1'b0;
      idx_q       <= '0;
      line_lo_q   <= '0;
      y_q         <= '0;
      vcnt_q      <= '0;
      pix_we_q    <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      line_num_q  <= '0;
      aux_we_q    <= 1'b0;
      aux_data_q  <= '0;
      frame_end_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pix_we_q    <= 1'b0;
      aux_we_q    <= 1'b0;
      frame_end_q <= 1'b0;
      if (!rx_dv) begin
        // Arm only after rx_dv has been seen low, so a frame cut by reset is skipped.
        arm_q <= 1'b1;
        if (in_frame_c) begin
          frame_end_q <= 1'b1;
          frame_ok_q  <= ok_c;
          if (!ok_c && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        end
        state_q    <= IDLE;
        sfd_seen_q <= 1'b0;
      end else if (rx_er && ((state_q != IDLE) || arm_q)) begin
        state_q <= DROP;
      end else begin
        case (state_q)
          IDLE: if (arm_q) state_q <= PRE;
          PRE: if (pvld_c) begin
            if (pb_c == 8'hD5) begin
              state_q    <= HDR;
              idx_q      <= '0;
              sfd_seen_q <= 1'b1;
              surplus_q  <= 1'b0;
            end else if (pb_c != 8'h55) begin
              state_q <= DROP;
            end
          end
          HDR: if (pvld_c) begin
            if (!hdr_byte_ok(idx_q, pb_c))   state_q <= DROP;
            else if (idx_q == 6'(HDR_LAST))  state_q <= PID;
            else                             idx_q   <= idx_q + 6'd1;
          end
          PID: if (pvld_c) begin
            idx_q <= '0;
            if (pb_c == 8'h00)      state_q <= LINE;
            else if (pb_c == 8'h01) state_q <= AUX;
            else                    state_q <= DROP;
          end
          LINE: if (pvld_c) begin
            if (!idx_q[0]) begin
              line_lo_q <= pb_c;
              idx_q     <= 6'd1;
            end else begin
              line_num_q <= {pb_c[3:0], line_lo_q};
              vcnt_q     <= '0;
              state_q    <= VIDEO;
            end
          end
          VIDEO: if (pvld_c) begin
            if (!vcnt_q[0]) begin
              y_q <= pb_c;
            end else begin
              pix_we_q   <= 1'b1;
              pix_data_q <= {y_q, pb_c};
              pix_x_q    <= vcnt_q[10:1];
            end
            vcnt_q <= vcnt_q + 11'd1;
            if (vcnt_q == (PIX_BYTES - 11'd1)) state_q <= DONE;
          end
          AUX: if (pvld_c) begin
            aux_we_q   <= 1'b1;
            aux_data_q <= pb_c;
          end
          DONE: if (pvld_c) surplus_q <= 1'b1;
          DROP: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pix_we    = pix_we_q;
  assign pix_data  = pix_data_q;
  assign pix_x     = pix_x_q;
  assign line_num  = line_num_q;
  assign aux_we    = aux_we_q;
  assign aux_data  = aux_data_q;
  assign frame_end = frame_end_q;
  assign frame_ok  = frame_ok_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gmii_rx_parser.sv
// Scoreboard bench for gmii_rx_parser: directed frames, expected writes queued at issue time.
module tb_gmii_rx_parser;

  logic        rx_clk = 1'b0;
  logic        sys_rst, rx_dv, rx_er;
  logic [7:0]  rxd;
  logic        pix_we, aux_we, frame_end, frame_ok;
  logic [15:0] pix_data, err_cnt;
  logic [9:0]  pix_x;
  logic [11:0] line_num;
  logic [7:0]  aux_data;

  gmii_rx_parser dut (
    .rx_clk(rx_clk), .sys_rst(sys_rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .pix_we(pix_we), .pix_data(pix_data), .pix_x(pix_x), .line_num(line_num),
    .aux_we(aux_we), .aux_data(aux_data), .frame_end(frame_end), .frame_ok(frame_ok),
    .err_cnt(err_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed { logic [15:0] d; logic [9:0] x; logic [11:0] ln; } pix_t;
  typedef struct packed { logic ok; logic [15:0] cnt; } fe_t;

  pix_t       pix_q[$];
  logic [7:0] aux_q[$];
  fe_t        fe_q[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Standard Ethernet FCS (complemented reflected CRC-32) over the frame bytes.
  function automatic logic [31:0] fcs32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_hdr(input logic [7:0] mac_last);
    logic [7:0] h[42];
    h = '{8'h00, 8'h23, 8'h45, 8'h67, 8'h89, 8'h00,
          8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h00,
          8'h45, 8'h00, 8'h05, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
          8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h02, 8'hC0, 8'hA8, 8'h01, 8'h01,
          8'h04, 8'hD2, 8'h30, 8'h39, 8'h05, 8'h1A, 8'h00, 8'h00};
    h[5] = mac_last;
    frm.delete();
    foreach (h[i]) frm.push_back(h[i]);
  endtask

  // Video payload: PID, line bytes (upper nibble of hi byte set to junk), nbytes pixels.
  task automatic add_video(input logic [11:0] ln, input int nbytes, input int mult, input bit expect_w);
    logic [7:0] a, b;
    frm.push_back(8'h00);
    frm.push_back(ln[7:0]);
    frm.push_back({4'hF, ln[11:8]});
    for (int i = 0; i < nbytes; i++) frm.push_back(8'((i * mult) % 256));
    if (expect_w)
      for (int k = 0; k < nbytes / 2; k++) begin
        a = 8'(((2 * k) * mult) % 256);
        b = 8'(((2 * k + 1) * mult) % 256);
        pix_q.push_back('{d: {a, b}, x: 10'(k), ln: ln});
      end
  endtask

  task automatic send_frame(input int gap, input int flip_bit);
    logic [31:0] f;
    f = fcs32(frm);
    if (flip_bit >= 0) f[flip_bit] = ~f[flip_bit];
    frm.push_back(f[7:0]); frm.push_back(f[15:8]);
    frm.push_back(f[23:16]); frm.push_back(f[31:24]);
    for (int i = 0; i < 8; i++) begin
      @(negedge rx_clk); rx_dv = 1'b1; rxd = (i == 7) ? 8'hD5 : 8'h55;
    end
    foreach (frm[i]) begin
      @(negedge rx_clk); rxd = frm[i];
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge rx_clk); rx_dv = 1'b0; rxd = 8'h00;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rx_clk); rx_dv = 1'b0; rxd = 8'h00;
    end
  endtask

  // Monitor: pops the expected entry whenever the DUT presents a write or frame end.
  task automatic monitor();
    pix_t p;
    fe_t  e;
    forever begin
      @(negedge rx_clk);
      if (!sys_rst) begin
        if (pix_we) begin
          if (pix_q.size() == 0) chk("pix_unexpected", {pix_data, pix_x}, 0);
          else begin
            p = pix_q.pop_front();
            chk("pix", {pix_data, pix_x, line_num}, {p.d, p.x, p.ln});
          end
        end
        if (aux_we) begin
          if (aux_q.size() == 0) chk("aux_unexpected", {56'h1, aux_data}, 0);
          else chk("aux", aux_data, aux_q.pop_front());
        end
        if (frame_end) begin
          if (fe_q.size() == 0) chk("frame_end_unexpected", {frame_ok, err_cnt}, 64'h1_0000_0000);
          else begin
            e = fe_q.pop_front();
            chk("frame_status", {frame_ok, err_cnt}, {e.ok, e.cnt});
          end
        end
      end
    end
  endtask

  task automatic drain_check(input string nm);
    for (int i = 0; i < 200 && (pix_q.size() + aux_q.size() + fe_q.size()) != 0; i++)
      @(negedge rx_clk);
    chk({nm, "_pix_left"}, pix_q.size(), 0);
    chk({nm, "_aux_left"}, aux_q.size(), 0);
    chk({nm, "_fe_left"},  fe_q.size(), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_pix_we"},  pix_we, 0);
    chk({nm, "_pix"},     {pix_data, pix_x, line_num}, 0);
    chk({nm, "_aux"},     {aux_we, aux_data}, 0);
    chk({nm, "_fe"},      {frame_end, frame_ok}, 0);
    chk({nm, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    sys_rst = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    fork monitor(); join_none
    repeat (4) @(negedge rx_clk);
    chk_zero("reset");
    sys_rst = 1'b0;
    idle(4);

    // 1: good video, line 2A5, pixels i mod 256; followed with a single idle cycle
    build_hdr(8'h02);
    add_video(12'h2A5, 1280, 1, 1'b1);
    fe_q.push_back('{ok: 1'b1, cnt: 16'd0});
    send_frame(1, -1);

    // 2: good aux, 49 bytes, back-to-back with frame 1
    build_hdr(8'h02);
    frm.push_back(8'h01);
    for (int i = 0; i < 49; i++) begin
      frm.push_back(8'((i * 7 + 3) % 256));
      aux_q.push_back(8'((i * 7 + 3) % 256));
    end
    fe_q.push_back('{ok: 1'b1, cnt: 16'd0});
    send_frame(6, -1);
    drain_check("t2");

    // 3: wrong destination MAC
    build_hdr(8'h03);
    frm.push_back(8'h01);
    for (int i = 0; i < 20; i++) frm.push_back(8'(i));
    fe_q.push_back('{ok: 1'b0, cnt: 16'd1});
    send_frame(6, -1);

    // 4: good video with one FCS bit flipped
    build_hdr(8'h02);
    add_video(12'h155, 1280, 5, 1'b1);
    fe_q.push_back('{ok: 1'b0, cnt: 16'd2});
    send_frame(6, 13);
    drain_check("t4");

    // 5: video truncated after 100 pixel bytes, then a good video frame
    build_hdr(8'h02);
    add_video(12'h7FF, 100, 1, 1'b1);
    fe_q.push_back('{ok: 1'b0, cnt: 16'd3});
    send_frame(3, -1);
    build_hdr(8'h02);
    add_video(12'h013, 1280, 3, 1'b1);
    fe_q.push_back('{ok: 1'b1, cnt: 16'd3});
    send_frame(6, -1);
    drain_check("t5");
    chk("t5_err_cnt", err_cnt, 3);

    // 6: rx_er mid-header, then reset mid-frame; nothing may come out
    build_hdr(8'h02);
    add_video(12'h0AA, 1280, 1, 1'b0);
    frm.push_back(8'h55); frm.push_back(8'h55); frm.push_back(8'hD5); frm.push_back(8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge rx_clk); rx_dv = 1'b1; rxd = (i == 7) ? 8'hD5 : 8'h55;
    end
    foreach (frm[i]) begin
      @(negedge rx_clk);
      if (i == 34) chk_zero("after_rst");
      rx_er   = (i == 10);
      sys_rst = (i == 30 || i == 31);
      rxd     = frm[i];
    end
    idle(30);
    drain_check("t6");
    chk_zero("t6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
